multi_clock_generator: RTL and testbench

Parametrised clock-divider bank that produces NUM_CH divided 50%-duty clocks plus single-cycle rise and fall strobes from one fast input clock. It replaces the fixed single-ratio divider pair in the top level that generates the CPU clock and the memory clock. It adds run-time ratio reprogramming for the GBC double-speed switch, a phase-align restart, and a run/pause gate. All outputs are registered in the I_CLK domain.

---
 rtl/multi_clock_generator_pkg.sv | 23 ++
 rtl/multi_clock_generator_channel.sv | 96 +++++++++
 rtl/multi_clock_generator.sv | 50 +++++
 tb/tb_multi_clock_generator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_clock_generator_pkg.sv
// Shared constants for the divided-clock bank: channel roles, speed-switch ratios, clamp helper.
`default_nettype none

package multi_clock_generator_pkg;

   localparam int CLKGEN_CNT_W = 4;

   localparam int CPU_CH = 0;
   localparam int MEM_CH = 1;

   // Half-periods in base-clock cycles; double speed halves the CPU ratio.
   localparam logic [CLKGEN_CNT_W-1:0] CPU_HALF_NORMAL = 4'd4;
   localparam logic [CLKGEN_CNT_W-1:0] CPU_HALF_DOUBLE = 4'd2;
   localparam logic [CLKGEN_CNT_W-1:0] MEM_HALF_NORMAL = 4'd2;
   localparam logic [CLKGEN_CNT_W-1:0] MEM_HALF_DOUBLE = 4'd1;

   function automatic logic [31:0] clamp_half(input logic [31:0] value);
      return (value == 32'd0) ? 32'd1 : value;
   endfunction

endpackage

`default_nettype wire

// File: rtl/multi_clock_generator_channel.sv
// One divided-clock channel: half-period counter, 50% output, strobes and deferred divisor load.
`default_nettype none

module multi_clock_generator_channel
   import multi_clock_generator_pkg::*;
#(
   parameter int               CNT_W      = CLKGEN_CNT_W,
   parameter logic [CNT_W-1:0] RESET_HALF = CNT_W'(2)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             align,
   input  logic             load,
   input  logic [CNT_W-1:0] load_half,
   output logic             div_clk,
   output logic             rise_stb,
   output logic             fall_stb,
   output logic             pending
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] pend_half;
   logic             pend;
   logic             clk_q;
   logic             rise_q;
   logic             fall_q;

   logic             toggle;
   logic             apply;
   logic [CNT_W-1:0] load_clamped;
   logic [CNT_W-1:0] reset_clamped;

   always_comb begin
      toggle        = run && (cnt == half - CNT_W'(1));
      // Only the falling toggle closes a full period, so a new ratio never splits one.
      apply         = toggle && clk_q && pend;
      load_clamped  = CNT_W'(clamp_half(32'(load_half)));
      reset_clamped = CNT_W'(clamp_half(32'(RESET_HALF)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         half      <= reset_clamped;
         pend_half <= reset_clamped;
         pend      <= 1'b0;
         clk_q     <= 1'b0;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
      end else if (align) begin
         cnt    <= '0;
         clk_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         pend   <= 1'b0;
         if (load) begin
            half      <= load_clamped;
            pend_half <= load_clamped;
         end else if (pend) begin
            half <= pend_half;
         end
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         if (run) begin
            if (toggle) begin
               cnt    <= '0;
               clk_q  <= ~clk_q;
               rise_q <= ~clk_q;
               fall_q <= clk_q;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
         if (apply) begin
            half <= pend_half;
            pend <= 1'b0;
         end
         // A coincident load lands after the old pending value has been applied.
         if (load) begin
            pend_half <= load_clamped;
            pend      <= 1'b1;
         end
      end
   end

   assign div_clk  = clk_q;
   assign rise_stb = rise_q;
   assign fall_stb = fall_q;
   assign pending  = pend;

endmodule

`default_nettype wire

// File: rtl/multi_clock_generator.sv
// Bank of NUM_CH divided clocks sharing run/align controls with per-channel divisor load.
`default_nettype none

module multi_clock_generator
   import multi_clock_generator_pkg::*;
#(
   parameter int                      NUM_CH       = 2,
   parameter int                      CNT_W        = CLKGEN_CNT_W,
   parameter int                      SEL_W        = 1,
   parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_HALF = {MEM_HALF_NORMAL, CPU_HALF_NORMAL}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              align,
   input  logic              div_load,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [CNT_W-1:0]  div_half,
   output logic [NUM_CH-1:0] div_clk,
   output logic [NUM_CH-1:0] rise_stb,
   output logic [NUM_CH-1:0] fall_stb,
   output logic [NUM_CH-1:0] pending
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic load_i;

      // Selects at or above NUM_CH never match, so they are dropped here.
      assign load_i = div_load && (32'(div_sel) == i);

      multi_clock_generator_channel #(
         .CNT_W      (CNT_W),
         .RESET_HALF (DEFAULT_HALF[i*CNT_W +: CNT_W])
      ) u_channel (
         .clk       (clk),
         .rst_n     (rst_n),
         .run       (run),
         .align     (align),
         .load      (load_i),
         .load_half (div_half),
         .div_clk   (div_clk[i]),
         .rise_stb  (rise_stb[i]),
         .fall_stb  (fall_stb[i]),
         .pending   (pending[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_multi_clock_generator.sv
// Directed and randomized checks of the clock bank against a period-phase reference model.
`default_nettype none

module tb_multi_clock_generator;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 4;
   localparam int SEL_W  = 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              run = 1'b0;
   logic              align = 1'b0;
   logic              div_load = 1'b0;
   logic [SEL_W-1:0]  div_sel = '0;
   logic [CNT_W-1:0]  div_half = '0;
   logic [NUM_CH-1:0] div_clk;
   logic [NUM_CH-1:0] rise_stb;
   logic [NUM_CH-1:0] fall_stb;
   logic [NUM_CH-1:0] pending;

   int checks = 0;
   int errors = 0;

   // Model: phase = run edges since the period started; high while phase >= half.
   int m_phase [NUM_CH];
   int m_half  [NUM_CH];
   int m_phalf [NUM_CH];
   bit m_pend  [NUM_CH];
   bit m_rise  [NUM_CH];
   bit m_fall  [NUM_CH];

   multi_clock_generator #(
      .NUM_CH       (NUM_CH),
      .CNT_W        (CNT_W),
      .SEL_W        (SEL_W),
      .DEFAULT_HALF ({4'd2, 4'd4})
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .align    (align),
      .div_load (div_load),
      .div_sel  (div_sel),
      .div_half (div_half),
      .div_clk  (div_clk),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb),
      .pending  (pending)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_half[0] = 4;
      m_half[1] = 2;
      for (int c = 0; c < NUM_CH; c++) begin
         m_phase[c] = 0;
         m_phalf[c] = m_half[c];
         m_pend[c]  = 1'b0;
         m_rise[c]  = 1'b0;
         m_fall[c]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      for (int c = 0; c < NUM_CH; c++) begin
         bit ld;
         int hv;
         ld = div_load && (int'(div_sel) == c);
         hv = (div_half == 0) ? 1 : int'(div_half);
         m_rise[c] = 1'b0;
         m_fall[c] = 1'b0;
         if (align) begin
            m_phase[c] = 0;
            if (ld) m_half[c] = hv;
            else if (m_pend[c]) m_half[c] = m_phalf[c];
            m_pend[c] = 1'b0;
         end else begin
            if (run) begin
               m_phase[c]++;
               if (m_phase[c] == m_half[c]) m_rise[c] = 1'b1;
               if (m_phase[c] == 2 * m_half[c]) begin
                  m_phase[c] = 0;
                  m_fall[c]  = 1'b1;
                  if (m_pend[c]) begin
                     m_half[c] = m_phalf[c];
                     m_pend[c] = 1'b0;
                  end
               end
            end
            if (ld) begin
               m_phalf[c] = hv;
               m_pend[c]  = 1'b1;
            end
         end
      end
   endtask

   task automatic check_vec(input string tag, input logic [NUM_CH-1:0] got,
                            input logic [NUM_CH-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [NUM_CH-1:0] e_clk, e_rise, e_fall, e_pend;
      for (int c = 0; c < NUM_CH; c++) begin
         e_clk[c]  = (m_phase[c] >= m_half[c]);
         e_rise[c] = m_rise[c];
         e_fall[c] = m_fall[c];
         e_pend[c] = m_pend[c];
      end
      check_vec("div_clk", div_clk, e_clk);
      check_vec("rise_stb", rise_stb, e_rise);
      check_vec("fall_stb", fall_stb, e_fall);
      check_vec("pending", pending, e_pend);
   endtask

   // Inputs change only after the sampling point, so each edge sees stable values.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
      div_load = 1'b0;
      align    = 1'b0;
   endtask

   initial begin
      model_reset();
      #12;
      check_vec("reset_clk", div_clk, 2'b00);
      check_vec("reset_pending", pending, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // Defaults: ch1 rises at edge 2, ch0 at edge 4 while ch1 falls.
      run = 1'b1;
      step();
      step();
      check_vec("edge2_clk", div_clk, 2'b10);
      check_vec("edge2_rise", rise_stb, 2'b10);
      step();
      step();
      check_vec("edge4_clk", div_clk, 2'b01);
      check_vec("edge4_rise", rise_stb, 2'b01);
      check_vec("edge4_fall", fall_stb, 2'b10);

      // Mid-high load on ch0: stays pending until the falling toggle at edge 8.
      div_load = 1'b1; div_sel = 1'b0; div_half = 4'd2;
      step();
      for (int k = 0; k < 12; k++) step();

      // Zero half on ch1 clamps to 1.
      div_load = 1'b1; div_sel = 1'b1; div_half = 4'd0;
      step();
      for (int k = 0; k < 10; k++) step();

      // Align with a pending value.
      div_load = 1'b1; div_sel = 1'b0; div_half = 4'd3;
      step();
      step();
      align = 1'b1;
      step();
      check_vec("align_clk", div_clk, 2'b00);
      check_vec("align_stb", rise_stb | fall_stb, 2'b00);
      for (int k = 0; k < 8; k++) step();

      // Pause mid-period.
      run = 1'b0;
      for (int k = 0; k < 5; k++) step();
      run = 1'b1;
      for (int k = 0; k < 10; k++) step();

      // Randomized traffic.
      for (int k = 0; k < 1500; k++) begin
         run      = ($urandom_range(0, 9) != 0);
         align    = ($urandom_range(0, 60) == 0);
         div_load = ($urandom_range(0, 12) == 0);
         div_sel  = SEL_W'($urandom_range(0, 1));
         div_half = CNT_W'($urandom_range(0, 15));
         step();
      end

      // Async reset mid-period with a load pending.
      run = 1'b1;
      div_load = 1'b1; div_sel = 1'b1; div_half = 4'd7;
      step();
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check_vec("async_clk", div_clk, 2'b00);
      check_vec("async_stb", rise_stb | fall_stb, 2'b00);
      check_vec("async_pending", pending, 2'b00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
